// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_pkg;

  // Checker sequencing: idle, gather samples, walk the table, report.
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    DONE
  } tt_state_t;

  // Number of truth-table rows for an n-input function.
  function automatic int TT_ROWS(input int n);
    return 1 << n;
  endfunction

  // Guia 2-input reference tables; bit i is the output for input vector i
  // where the vector MSB is input a.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/tt_row_cmp.sv
// Per-row comparator used while walking the table: flags a row whose
// observed value disagrees with the reference and produces the updated
// mismatch count and first-error index.
module tt_row_cmp #(
  parameter int N_IN = 2
) (
  input  logic            obs_bit,
  input  logic            exp_bit,
  input  logic [N_IN-1:0] idx,
  input  logic [N_IN:0]   cnt,
  input  logic [N_IN-1:0] first_idx,
  output logic [N_IN:0]   cnt_next,
  output logic [N_IN-1:0] first_next
);

  logic row_err;

  // The first-error index is loaded only while the count is still zero,
  // so later mismatches never overwrite the lowest failing row.
  always_comb begin
    row_err    = obs_bit ^ exp_bit;
    cnt_next   = cnt + (N_IN + 1)'(row_err);
    first_next = first_idx;
    if (row_err && (cnt == '0)) begin
      first_next = idx;
    end
  end

endmodule

// File: rtl/tt_checker.sv
// On-chip truth-table checker: gathers (vector, output) samples until every
// row has been seen, then compares the captured table row by row against
// the reference and reports pass/fail, mismatch count and first bad row.
module tt_checker
  import tt_pkg::*;
#(
  parameter int                          N_IN     = 2,
  parameter logic [TT_ROWS(N_IN)-1:0]    EXPECTED = TT_XOR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_vec,
  input  logic                      in_s,
  output logic [TT_ROWS(N_IN)-1:0]  observed,
  output logic [TT_ROWS(N_IN)-1:0]  seen,
  output logic                      conflict,
  output logic [N_IN:0]             mismatch_cnt,
  output logic [N_IN-1:0]           first_err_idx,
  output logic                      done,
  output logic                      pass
);

  localparam int                ROWS     = TT_ROWS(N_IN);
  localparam int                IDX_W    = N_IN + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [ROWS-1:0]   ALL_SEEN = '1;

  tt_state_t        state;
  logic [IDX_W-1:0] idx;
  logic [ROWS-1:0]  seen_after;
  logic [N_IN:0]    cnt_next;
  logic [N_IN-1:0]  first_next;

  // Seen mask as it would look if the current sample were accepted; used
  // to detect the accept that completes the table.
  always_comb begin
    seen_after = seen | (ROWS'(1) << in_vec);
  end

  tt_row_cmp #(
    .N_IN (N_IN)
  ) u_row_cmp (
    .obs_bit    (observed[idx[N_IN-1:0]]),
    .exp_bit    (EXPECTED[idx[N_IN-1:0]]),
    .idx        (idx[N_IN-1:0]),
    .cnt        (mismatch_cnt),
    .first_idx  (first_err_idx),
    .cnt_next   (cnt_next),
    .first_next (first_next)
  );

  // Main sequencer; start always wins (even over a same-cycle sample), and
  // in_ready is registered alongside the state so it never depends on
  // in_valid. DONE spends one edge latching done/pass from the final count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      in_ready      <= 1'b0;
      observed      <= '0;
      seen          <= '0;
      conflict      <= 1'b0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (start) begin
      state         <= COLLECT;
      idx           <= '0;
      in_ready      <= 1'b1;
      observed      <= '0;
      seen          <= '0;
      conflict      <= 1'b0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b0;
        end
        COLLECT: begin
          if (in_valid && in_ready) begin
            if (!seen[in_vec]) begin
              observed[in_vec] <= in_s;
              seen[in_vec]     <= 1'b1;
              if (seen_after == ALL_SEEN) begin
                state    <= CHECK;
                in_ready <= 1'b0;
                idx      <= '0;
              end
            end else if (observed[in_vec] != in_s) begin
              conflict <= 1'b1;
            end
          end
        end
        CHECK: begin
          mismatch_cnt  <= cnt_next;
          first_err_idx <= first_next;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          in_ready <= 1'b0;
          if (!done) begin
            done <= 1'b1;
            pass <= (mismatch_cnt == '0) && !conflict;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_checker.sv
// Scoreboard bench for tt_checker: each pass pushes its hand-computed result
// into a queue, and a monitor pops and compares whenever done rises.
module tb_tt_checker;
  import tt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_vec;
  logic       in_s;
  logic [3:0] observed;
  logic [3:0] seen;
  logic       conflict;
  logic [2:0] mismatch_cnt;
  logic [1:0] first_err_idx;
  logic       done;
  logic       pass;

  typedef struct {
    logic [3:0] observed;
    logic       conflict;
    logic [2:0] cnt;
    logic [1:0] first;
    logic       pass;
    int         latency;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   ref_cyc;
  int   last_acc_cyc;
  logic done_prev;

  tt_checker #(
    .N_IN     (2),
    .EXPECTED (TT_XOR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vec        (in_vec),
    .in_s          (in_s),
    .observed      (observed),
    .seen          (seen),
    .conflict      (conflict),
    .mismatch_cnt  (mismatch_cnt),
    .first_err_idx (first_err_idx),
    .done          (done),
    .pass          (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time done relative to start or the last accept.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // One sample, optionally preceded by idle cycles; returns #1 after the
  // edge that samples it.
  task automatic applyStimulus(input logic [1:0] vec, input logic s, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_vec   = vec;
    in_s     = s;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic startPass();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    ref_cyc = cyc;
  endtask

  task automatic feedTable(input logic [3:0] tbl);
    for (int i = 0; i < 4; i++) applyStimulus(2'(i), tbl[i], 0);
  endtask

  task automatic pushExp(input logic [3:0] obs, input logic cf, input logic [2:0] cnt,
                         input logic [1:0] first, input logic ps, input int lat);
    exp_t e;
    e.observed = obs;
    e.conflict = cf;
    e.cnt      = cnt;
    e.first    = first;
    e.pass     = ps;
    e.latency  = lat;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Monitor: on each rising done, compare the reported result with the
  // oldest expected entry.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("observed", 32'(observed), 32'(e.observed));
        checkOutput("seen", 32'(seen), 32'hF);
        checkOutput("conflict", 32'(conflict), 32'(e.conflict));
        checkOutput("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
        if (e.cnt != 0) checkOutput("first_err_idx", 32'(first_err_idx), 32'(e.first));
        checkOutput("pass", 32'(pass), 32'(e.pass));
        checkOutput("in_ready_done", 32'(in_ready), 0);
        checkOutput("done_latency", 32'(cyc - ref_cyc), 32'(e.latency));
      end
    end
    done_prev = done;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    ref_cyc   = 0;
    done_prev = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 2'd0;
    in_s      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_observed", 32'(observed), 0);
    checkOutput("rst_seen", 32'(seen), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_pass", 32'(pass), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);

    $display("[TB] XOR in order, back-to-back");
    pushExp(4'b0110, 1'b0, 3'd0, 2'd0, 1'b1, 9);
    startPass();
    checkOutput("ready_after_start", 32'(in_ready), 1);
    feedTable(TT_XOR);
    waitDrain();

    $display("[TB] AND table against XOR reference");
    pushExp(4'b1000, 1'b0, 3'd3, 2'd1, 1'b0, 5);
    startPass();
    feedTable(TT_AND);
    ref_cyc = last_acc_cyc;
    waitDrain();

    $display("[TB] out of order with duplicate and gaps");
    pushExp(4'b0110, 1'b0, 3'd0, 2'd0, 1'b1, 5);
    startPass();
    applyStimulus(2'd3, 1'b0, 1);
    applyStimulus(2'd0, 1'b0, 2);
    applyStimulus(2'd0, 1'b0, 0);
    applyStimulus(2'd2, 1'b1, 3);
    checkOutput("ready_before_last", 32'(in_ready), 1);
    applyStimulus(2'd1, 1'b1, 1);
    ref_cyc = last_acc_cyc;
    checkOutput("ready_in_check", 32'(in_ready), 0);
    waitDrain();

    $display("[TB] conflicting resample of row 2");
    pushExp(4'b0110, 1'b1, 3'd0, 2'd0, 1'b0, 5);
    startPass();
    applyStimulus(2'd2, 1'b1, 0);
    applyStimulus(2'd2, 1'b0, 0);
    checkOutput("conflict_sticky", 32'(conflict), 1);
    applyStimulus(2'd0, 1'b0, 0);
    applyStimulus(2'd1, 1'b1, 0);
    applyStimulus(2'd3, 1'b0, 0);
    ref_cyc = last_acc_cyc;
    waitDrain();

    $display("[TB] reset mid-check");
    startPass();
    feedTable(TT_XOR);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_observed", 32'(observed), 0);
    checkOutput("midrst_seen", 32'(seen), 0);
    checkOutput("midrst_cnt", 32'(mismatch_cnt), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_vec   = 2'(i);
      in_s     = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("idle_seen", 32'(seen), 0);
    checkOutput("idle_observed", 32'(observed), 0);
    checkOutput("idle_done", 32'(done), 0);

    $display("[TB] restart during collect");
    startPass();
    applyStimulus(2'd0, 1'b0, 0);
    applyStimulus(2'd1, 1'b1, 0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 2'd3;
    in_s     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    ref_cyc  = cyc;
    checkOutput("restart_seen", 32'(seen), 0);
    checkOutput("restart_observed", 32'(observed), 0);
    checkOutput("restart_in_ready", 32'(in_ready), 1);
    pushExp(4'b0110, 1'b0, 3'd0, 2'd0, 1'b1, 9);
    feedTable(TT_XOR);
    waitDrain();

    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_held", 32'(done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_checker.md
# tt_checker

- Hardware response checker for the Guia 2-input logic exercises.
- Consumes (input vector, DUT output) samples, one per handshake, and builds the observed truth table.
- Then walks the table entry by entry against an expected truth table and reports pass/fail, mismatch count and the first failing row.
- Sits downstream of a stimulus sequencer and the DUT, so an exhaustive self-check runs on-chip instead of by reading a printed monitor.

## Interface
- `N_IN`, default 2: number of DUT inputs; the table has 2**N_IN rows.
- `EXPECTED`, default 4'b0110: expected output per row; bit i is the row where the input vector equals i.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle pulse; clears results and begins a collection pass.
- `in_valid`  in  1: sample present on `in_vec`/`in_s`.
- `in_ready`  out  1: checker accepts a sample this cycle.
- `in_vec`  in  N_IN: DUT input vector of the sample (MSB = first input, i.e. `a`).
- `in_s`  in  1: DUT output for that vector.
- `observed`  out  2**N_IN: captured truth table.
- `seen`  out  2**N_IN: row-captured flags.
- `conflict`  out  1: a row was re-sampled with a different value.
- `mismatch_cnt`  out  N_IN+1: rows where observed differs from EXPECTED.
- `first_err_idx`  out  N_IN: lowest failing row; valid only when `mismatch_cnt` is non-zero.
- `done`  out  1: check complete; held until the next `start` or reset.
- `pass`  out  1: `done` and zero mismatches and no conflict.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE; every output and internal register is 0; any pass in progress is discarded.
- IDLE
  - `in_ready`=0.
  - `start` clears `observed`, `seen`, `conflict`, `mismatch_cnt`, `first_err_idx`, `done` and `pass`, then moves to COLLECT.
- COLLECT
  - `in_ready`=1.
  - Accept occurs when `in_valid` and `in_ready` are both high: `observed[in_vec]`<=`in_s` and `seen[in_vec]`<=1.
  - Accepting a row whose `seen` bit is already set:
    - keeps the first value;
    - sets `conflict` (sticky) if `in_s` differs;
    - otherwise the accept is a no-op.
  - When the accept completes `seen` (all ones), the next state is CHECK.
- CHECK
  - `in_ready`=0.
  - An index counter runs from 0 to 2**N_IN-1, one row per cycle.
  - On `observed[idx]` != `EXPECTED[idx]`, increment `mismatch_cnt`.
  - On the first mismatch only, load `first_err_idx`<=idx.
  - After the last row, go to DONE.
- DONE
  - `done`=1 and `pass` are registered outputs; `in_ready`=0.
  - `start` behaves as in IDLE.
- `start` in COLLECT or CHECK aborts and restarts: results are cleared and the state becomes COLLECT.
- `start` has priority over a same-cycle accept; that sample is dropped.
- `in_valid` outside COLLECT is ignored; no state changes.
- Widths: `mismatch_cnt` is N_IN+1 bits and cannot overflow, since its maximum is 2**N_IN.
- The index counter is N_IN+1 bits internally; termination is at idx = 2**N_IN-1 and the counter does not wrap.

## Timing
- `start` at edge t: `in_ready`=1 from t+1.
- Completing accept at edge t: CHECK spans edges t+1 … t+2**N_IN.
- `done` is high after edge t+1+2**N_IN; that is 5 cycles after the last accept for N_IN=2.
- A fully back-to-back pass of 2**N_IN accepts therefore has `done` 2*2**N_IN+1 cycles after `start`.
- `in_ready` depends only on state and is registered, with no combinational path from `in_valid`.

## Structure
- Shared package `tt_pkg`:
  - state enum {IDLE, COLLECT, CHECK, DONE};
  - `TT_ROWS(n)` = 2**n helper;
  - Guia expected-table constants (AND, OR, XOR, NAND …) for reuse by benches and top levels.
- Optional sub-module `tt_row_cmp`: the per-row comparator plus first-error capture used in CHECK.
- Everything else is one module of roughly 150–250 lines.

## Test plan
- XOR DUT model, rows fed in order 0,1,2,3, back-to-back after `start`:
  - `observed`=4'b0110, `mismatch_cnt`=0, `pass`=1;
  - `done` 9 cycles after `start`.
- AND DUT model (observed 4'b1000) against EXPECTED=4'b0110:
  - `mismatch_cnt`=3, `first_err_idx`=1, `pass`=0.
- Rows fed in order 3,0,0(same value),2,1 with `in_valid` gaps:
  - duplicate ignored, `conflict`=0;
  - CHECK starts the cycle after row 1;
  - `pass`=1.
- Row 2 fed as 1 then as 0 (XOR model otherwise):
  - `observed[2]`=1, `conflict`=1, `mismatch_cnt`=0, `pass`=0.
- `rst_n`=0 for one edge mid-CHECK:
  - all outputs 0, state IDLE;
  - `in_valid` afterwards has no effect until `start`.
- `start` during COLLECT after 2 accepts, together with an `in_valid` on row 3:
  - `seen`=0000;
  - the row 3 sample is dropped;
  - a full new pass then completes normally.
